uart_tx_frame_engine: RTL and testbench
=======================================

Name: uart_tx_frame_engine

Overview:
- Parametrised next-generation UART transmitter for the FPGA UART.
- Serialises characters of 5..9 data bits, LSB first.
- Parity mode is selectable per character: none, even, odd or mark. Stop length is 1, 1.5 or 2 bits.
- A one-deep holding register with a valid/ready handshake lets back-to-back frames go out with zero idle gap.
- Sits between the register/FIFO front end and the pad, and is clocked by the shared baud oversample tick.

Parameters:
- MAX_UART_DATA_W, 9, widest character supported; legal range 5..9.
- OVERSAMPLE, 16, baud_en_i ticks per bit; must be even and at least 4.
- SAMPLE_COUNT_W, $clog2(3*OVERSAMPLE/2), width of the tick counter; sized to cover a 1.5-bit stop.
- TOTAL_CONF_W, 7, width of the configuration field {data_len[2:0], stop[1:0], parity[1:0]}.

Ports:
- clk_i  in  1  Top clock.
- rst_i  in  1  Reset; asynchronous, active-high.
- baud_en_i  in  1  Oversample tick; one clk wide.
- tx_en_i  in  1  Enable; when low, no new character is accepted.
- tx_valid_i  in  1  Character and configuration are offered.
- tx_ready_o  out  1  Holding register can accept a character.
- tx_conf_i  in  TOTAL_CONF_W  Configuration, captured together with the data.
- tx_data_i  in  MAX_UART_DATA_W  Character; unused high bits are ignored.
- tx_break_i  in  1  Break request (optional feature).
- tx_done_o  out  1  One-clk pulse at the end of each frame.
- tx_busy_o  out  1  A frame is in progress or the holding register is full.
- uart_tx_o  out  1  Serial line; registered, idles high.

Behaviour:
- Reset values: uart_tx_o=1, tx_ready_o=0, tx_busy_o=0, tx_done_o=0, state=Idle, holding register empty.
- Reset asserted mid-frame aborts the frame immediately, without waiting for a clock.
- tx_ready_o = tx_en_i AND holding register empty (registered).
- Accept: when tx_valid_i and tx_ready_o are both high at a clk edge, data and conf are captured regardless of baud_en_i. tx_ready_o is low on the next cycle.
- data_len codes 0..4 select 5..9 bits; codes 5..7 select 9 bits. The selected length is then clamped to MAX_UART_DATA_W.
- stop codes: 0 selects 1 bit, 1 selects 1.5 bits (3*OVERSAMPLE/2 ticks), 2 and 3 select 2 bits.
- parity codes: 0 none, 1 even, 2 odd, 3 mark (always 1). Parity is computed over the selected bits only.
- State machine, advanced only on clk edges where baud_en_i=1:
  - Idle: uart_tx_o=1. If the holding register is full, move to Start, move the holding register into the shift register, and mark the holding register empty.
  - Start: drive 0 for OVERSAMPLE ticks.
  - Data: drive the current data bit, LSB first, OVERSAMPLE ticks per bit.
  - Parity: only entered when parity code is nonzero; drive the parity bit for OVERSAMPLE ticks.
  - Stop: drive 1 for the configured tick count.
- Stop exit on its last tick:
  - If the holding register is full and tx_en_i=1, go directly to Start (no idle bit).
  - Otherwise go to Idle.
- uart_tx_o changes on the same clk edge as the state or bit transition, from registered logic only.
- tx_done_o pulses high for one clk on the final stop tick.
- tx_busy_o is high from the Idle->Start transition through the last stop tick, and is also high whenever the holding register is full.
- tx_en_i deasserted mid-frame: the current frame completes. A character already held is still sent; no further characters are accepted.
- Accept on the same clk edge that the holding register is drained is legal, because the ready flag came from the previous cycle.

Optional Feature:
- Macro: UART_TX_BREAK_EN.
- Defined:
  - tx_break_i=1 in Idle forces uart_tx_o=0 from the next clk edge.
  - While break is asserted, no frame is launched.
  - If break is asserted mid-frame, it takes effect after the stop bits complete.
  - Deasserting break returns the line to 1; a launch is allowed on the following tick.
- Undefined: tx_break_i is ignored and the port stays present.

Decomposition:
- Package uart_pkg holds:
  - state encodings;
  - parity-mode constants PAR_NONE, PAR_EVEN, PAR_ODD, PAR_MARK;
  - stop-code constants;
  - DATA_LEN_OFFSET=5;
  - the conf field bit positions shared with the receiver.
- Sub-module uart_tx_hold_reg: one-deep valid/ready holding register with a drain strobe and full flag.

Test Plan:
- 8N1 (conf data=3, stop=0, parity=0), 0xA5, OVERSAMPLE=16, baud_en_i every 4 clk -> line 0,1,0,1,0,0,1,0,1,1 with each bit 64 clk wide. Exactly one tx_done_o pulse; busy drops after it.
- 7E2, 0x41 -> 7 data bits 1000001, then parity 0, then two stop bits. Check 9O1.5 with 0x1FF -> parity 0 and a stop lasting 24 ticks.
- Back-to-back 0x55 then 0xAA, second offered during the first frame -> second start bit begins on the tick after the first frame's last stop tick. tx_ready_o low only while held.
- rst_i pulsed asynchronously mid-Data -> uart_tx_o=1 before the next clk edge; ready/busy/done at reset values; the next character transmits cleanly.
- tx_en_i dropped during a frame with a character held -> both frames complete, and tx_ready_o stays 0.
- With UART_TX_BREAK_EN, tx_break_i during a frame -> line goes 0 only after the stop bits. A held character is not sent until break is deasserted.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, parity/stop codes, conf layout.
// Conf word layout is {data_len[2:0], stop[1:0], parity[1:0]}.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;
    localparam logic [1:0] PAR_MARK = 2'd3;

    localparam logic [1:0] STOP_1   = 2'd0;
    localparam logic [1:0] STOP_1P5 = 2'd1;
    localparam logic [1:0] STOP_2   = 2'd2;

    localparam int DATA_LEN_OFFSET = 5;

    localparam int CONF_PAR_LSB  = 0;
    localparam int CONF_PAR_W    = 2;
    localparam int CONF_STOP_LSB = 2;
    localparam int CONF_STOP_W   = 2;
    localparam int CONF_LEN_LSB  = 4;
    localparam int CONF_LEN_W    = 3;

    function automatic logic [3:0] data_len(input logic [2:0] code,
                                            input int max_w);
        int n;
        n = (code <= 3'd4) ? int'(code) + DATA_LEN_OFFSET : 9;
        if (n > max_w) begin
            n = max_w;
        end
        return 4'(n);
    endfunction

endpackage

// File: rtl/uart_tx_hold_reg.sv
// One-deep valid/ready holding register in front of the UART shifter.
// Ready is registered and already reflects a capture in the same cycle.
module uart_tx_hold_reg
    import uart_pkg::*;
#(
    parameter int DATA_W = 9,
    parameter int CONF_W = 7
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CONF_W-1:0] conf_i,
    input  logic              drain_i,
    output logic              ready_o,
    output logic              full_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CONF_W-1:0] conf_o
);

    logic              full_q, full_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] data_q;
    logic [CONF_W-1:0] conf_q;
    logic              accept;

    always_comb begin
        accept  = valid_i & ready_q;
        full_d  = accept | (full_q & ~drain_i);
        ready_d = en_i & ~full_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q  <= 1'b0;
            ready_q <= 1'b0;
            data_q  <= '0;
            conf_q  <= '0;
        end else begin
            full_q  <= full_d;
            ready_q <= ready_d;
            if (accept) begin
                data_q <= data_i;
                conf_q <= conf_i;
            end
        end
    end

    assign ready_o = ready_q;
    assign full_o  = full_q;
    assign data_o  = data_q;
    assign conf_o  = conf_q;

endmodule

// File: rtl/uart_tx_frame_engine.sv
// UART transmit frame engine: 5..9 data bits, parity, 1/1.5/2 stop bits.
// Optional line break support is enabled with `define UART_TX_BREAK_EN.
module uart_tx_frame_engine
    import uart_pkg::*;
#(
    parameter int MAX_UART_DATA_W = 9,
    parameter int OVERSAMPLE      = 16,
    parameter int SAMPLE_COUNT_W  = $clog2(3 * OVERSAMPLE / 2),
    parameter int TOTAL_CONF_W    = 7
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       baud_en_i,
    input  logic                       tx_en_i,
    input  logic                       tx_valid_i,
    output logic                       tx_ready_o,
    input  logic [TOTAL_CONF_W-1:0]    tx_conf_i,
    input  logic [MAX_UART_DATA_W-1:0] tx_data_i,
    input  logic                       tx_break_i,
    output logic                       tx_done_o,
    output logic                       tx_busy_o,
    output logic                       uart_tx_o
);

    localparam logic [SAMPLE_COUNT_W-1:0] CNT_FULL =
        SAMPLE_COUNT_W'(OVERSAMPLE - 1);
    localparam logic [SAMPLE_COUNT_W-1:0] CNT_HALF =
        SAMPLE_COUNT_W'(OVERSAMPLE / 2 - 1);

    logic                       hold_full;
    logic                       launch;
    logic [MAX_UART_DATA_W-1:0] hold_data;
    logic [TOTAL_CONF_W-1:0]    hold_conf;
    logic [3:0]                 hold_len;
    logic [MAX_UART_DATA_W-1:0] hold_masked;
    logic [1:0]                 hold_par_mode;
    logic                       hold_par;
    logic                       brk;

    tx_state_e                  state_q, state_d;
    logic [SAMPLE_COUNT_W-1:0]  cnt_q, cnt_d;
    logic [SAMPLE_COUNT_W-1:0]  slot_last;
    logic [3:0]                 bit_q, bit_d;
    logic [3:0]                 last_q, last_d;
    logic [MAX_UART_DATA_W-1:0] shift_q, shift_d;
    logic [1:0]                 stop_q, stop_d;
    logic                       par_en_q, par_en_d;
    logic                       par_bit_q, par_bit_d;
    logic                       tx_q, tx_d;
    logic                       slot_end;
    logic                       frame_end;
    logic                       done;

`ifdef UART_TX_BREAK_EN
    assign brk = tx_break_i;
`else
    logic unused_break;
    assign brk = 1'b0;
    assign unused_break = tx_break_i;
`endif

    uart_tx_hold_reg #(
        .DATA_W (MAX_UART_DATA_W),
        .CONF_W (TOTAL_CONF_W)
    ) u_hold (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (tx_en_i),
        .valid_i (tx_valid_i),
        .data_i  (tx_data_i),
        .conf_i  (tx_conf_i),
        .drain_i (launch),
        .ready_o (tx_ready_o),
        .full_o  (hold_full),
        .data_o  (hold_data),
        .conf_o  (hold_conf)
    );

    // Parity only covers the bits that will actually be shifted out.
    always_comb begin
        hold_len = data_len(hold_conf[CONF_LEN_LSB +: CONF_LEN_W],
                            MAX_UART_DATA_W);
        for (int i = 0; i < MAX_UART_DATA_W; i++) begin
            hold_masked[i] = hold_data[i] & (4'(i) < hold_len);
        end
        hold_par_mode = hold_conf[CONF_PAR_LSB +: CONF_PAR_W];
        hold_par = 1'b0;
        case (hold_par_mode)
            PAR_EVEN: hold_par = ^hold_masked;
            PAR_ODD:  hold_par = ~^hold_masked;
            PAR_MARK: hold_par = 1'b1;
            default:  hold_par = 1'b0;
        endcase
    end

    // The second slot of a 1.5-bit stop is only half a bit long.
    always_comb begin
        slot_last = CNT_FULL;
        if (state_q == ST_STOP && stop_q == STOP_1P5 && bit_q[0]) begin
            slot_last = CNT_HALF;
        end
        slot_end  = baud_en_i && (cnt_q == slot_last);
        frame_end = (state_q == ST_STOP) && slot_end &&
                    (bit_q[0] || stop_q == STOP_1);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        last_d    = last_q;
        shift_d   = shift_q;
        stop_d    = stop_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        tx_d      = tx_q;
        launch    = 1'b0;
        done      = 1'b0;

        if (state_q != ST_IDLE && baud_en_i) begin
            cnt_d = slot_end ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                tx_d   = ~brk;
                launch = baud_en_i & hold_full & ~brk;
            end
            ST_START: begin
                if (slot_end) begin
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (slot_end) begin
                    if (bit_q == last_q) begin
                        bit_d   = '0;
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                        tx_d    = par_en_q ? par_bit_q : 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (slot_end) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                    bit_d   = '0;
                end
            end
            ST_STOP: begin
                if (frame_end) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                    launch  = hold_full & tx_en_i & ~brk;
                end else if (slot_end) begin
                    bit_d = 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        if (launch) begin
            state_d   = ST_START;
            cnt_d     = '0;
            bit_d     = '0;
            tx_d      = 1'b0;
            shift_d   = hold_data;
            last_d    = hold_len - 4'd1;
            stop_d    = hold_conf[CONF_STOP_LSB +: CONF_STOP_W];
            par_en_d  = (hold_par_mode != PAR_NONE);
            par_bit_d = hold_par;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            last_q    <= '0;
            shift_q   <= '0;
            stop_q    <= STOP_1;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            last_q    <= last_d;
            shift_q   <= shift_d;
            stop_q    <= stop_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
        end
    end

    assign uart_tx_o = tx_q;
    assign tx_done_o = done;
    assign tx_busy_o = (state_q != ST_IDLE) | hold_full;

endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// Bench for uart_tx_frame_engine: per-tick line model plus directed checks.
// Break behaviour is exercised according to UART_TX_BREAK_EN.
module tb_uart_tx_frame_engine;

    localparam int OS = 16;
    localparam int MW = 9;
    localparam logic [6:0] C8N1 = 7'b011_00_00;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_en;
    logic       tx_en;
    logic       tx_valid;
    logic       tx_ready;
    logic [6:0] tx_conf;
    logic [8:0] tx_data;
    logic       tx_break;
    logic       tx_done;
    logic       tx_busy;
    logic       uart_tx;

    uart_tx_frame_engine dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .baud_en_i  (baud_en),
        .tx_en_i    (tx_en),
        .tx_valid_i (tx_valid),
        .tx_ready_o (tx_ready),
        .tx_conf_i  (tx_conf),
        .tx_data_i  (tx_data),
        .tx_break_i (tx_break),
        .tx_done_o  (tx_done),
        .tx_busy_o  (tx_busy),
        .uart_tx_o  (uart_tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] d;
        logic [6:0] c;
    } ch_t;

    int  n_vec = 0;
    int  n_err = 0;
    int  tick_idx = 0;
    int  bcnt = 0;
    ch_t model_q[$];
    bit  exp_lv[$];
    int  starts_q[$];
    int  lens_q[$];
    bit  inframe = 0;
    bit  mon_on = 0;
    bit  prev_tick = 0;
    int  k_pos, f_start, f_bad;
    int  frames_done = 0;
    int  done_pulses = 0;
    int  exp_done_idx = -1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected line level for every baud tick of one frame.
    function automatic void fill(input ch_t ch);
        int len, st, ones;
        bit p;
        exp_lv.delete();
        len = (ch.c[6:4] <= 3'd4) ? int'(ch.c[6:4]) + 5 : 9;
        if (len > MW) len = MW;
        st = (ch.c[3:2] == 2'd0) ? OS :
             (ch.c[3:2] == 2'd1) ? (3 * OS / 2) : 2 * OS;
        ones = 0;
        for (int i = 0; i < len; i++) ones += int'(ch.d[i]);
        case (ch.c[1:0])
            2'd1:    p = (ones % 2) == 1;
            2'd2:    p = (ones % 2) == 0;
            2'd3:    p = 1'b1;
            default: p = 1'b0;
        endcase
        repeat (OS) exp_lv.push_back(1'b0);
        for (int i = 0; i < len; i++) repeat (OS) exp_lv.push_back(ch.d[i]);
        if (ch.c[1:0] != 2'd0) repeat (OS) exp_lv.push_back(p);
        repeat (st) exp_lv.push_back(1'b1);
    endfunction

    initial begin
        baud_en = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            bcnt = (bcnt + 1) % 4;
            baud_en = (bcnt == 0);
        end
    end

    // Line monitor: at each negedge, uart_tx holds the value from the
    // previous posedge and baud_en/tx_done refer to the next posedge.
    initial begin
        forever begin
            @(negedge clk);
            if (!mon_on) begin
                inframe = 0;
                model_q.delete();
                prev_tick = baud_en;
                continue;
            end
            if (tx_valid && tx_ready) model_q.push_back('{d: tx_data, c: tx_conf});
            if (prev_tick) begin
                tick_idx++;
                if (!inframe && uart_tx === 1'b0) begin
                    check("start_has_char", 32'(model_q.size() > 0), 1);
                    if (model_q.size() > 0) begin
                        fill(model_q.pop_front());
                        inframe = 1;
                        k_pos = 0;
                        f_bad = 0;
                        f_start = tick_idx;
                        starts_q.push_back(tick_idx);
                        lens_q.push_back(exp_lv.size());
                    end
                end
                if (inframe) begin
                    if (uart_tx !== exp_lv[k_pos]) f_bad++;
                    k_pos++;
                    if (k_pos == exp_lv.size()) begin
                        inframe = 0;
                        check("frame_ticks_bad", f_bad, 0);
                        frames_done++;
                        exp_done_idx = f_start + k_pos;
                    end
                end
            end
            if (tx_done === 1'b1) begin
                done_pulses++;
                check("done_tick", baud_en ? tick_idx + 1 : -1, exp_done_idx);
            end
            prev_tick = baud_en;
        end
    end

    task automatic send(input logic [8:0] d, input logic [6:0] c);
        bit ok;
        @(posedge clk);
        #2;
        tx_data = d;
        tx_conf = c;
        tx_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (tx_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #2;
        tx_valid = 1'b0;
        check("accept_timeout", ok, 1);
        @(negedge clk);
        check("ready_after_accept", tx_ready, 0);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!tx_busy && !inframe) begin
                ok = 1;
                break;
            end
        end
        check("idle_timeout", ok, 1);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, d0, n0;
        rst = 1'b1;
        tx_en = 1'b1;
        tx_valid = 1'b0;
        tx_break = 1'b0;
        tx_conf = '0;
        tx_data = '0;
        repeat (3) @(negedge clk);
        check("rst_line", uart_tx, 1);
        check("rst_ready", tx_ready, 0);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        mon_on = 1;
        repeat (2) @(negedge clk);
        check("ready_after_rst", tx_ready, 1);

        f0 = frames_done;
        d0 = done_pulses;
        send(9'h0A5, C8N1);
        wait_idle();
        check("8n1_frames", frames_done - f0, 1);
        check("8n1_done_pulses", done_pulses - d0, 1);
        check("8n1_busy_after", tx_busy, 0);

        send(9'h041, 7'b010_10_01);
        wait_idle();
        send(9'h1FF, 7'b100_01_10);
        wait_idle();
        check("7e2_9o15_frames", frames_done - f0, 3);

        n0 = starts_q.size();
        send(9'h055, C8N1);
        send(9'h0AA, C8N1);
        @(negedge clk);
        check("ready_while_held", tx_ready, 0);
        check("busy_while_held", tx_busy, 1);
        wait_idle();
        check("b2b_frames", starts_q.size() - n0, 2);
        check("b2b_gap", starts_q[n0 + 1], starts_q[n0] + lens_q[n0]);

        send(9'h000, C8N1);
        repeat (200) @(posedge clk);
        #3;
        check("pre_rst_line", uart_tx, 0);
        mon_on = 0;
        rst = 1'b1;
        #1;
        check("async_rst_line", uart_tx, 1);
        check("async_rst_ready", tx_ready, 0);
        check("async_rst_busy", tx_busy, 0);
        check("async_rst_done", tx_done, 0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #2;
        mon_on = 1;
        f0 = frames_done;
        send(9'h03C, C8N1);
        wait_idle();
        check("post_rst_frames", frames_done - f0, 1);

        f0 = frames_done;
        send(9'h123, 7'b100_00_01);
        send(9'h0F0, C8N1);
        @(posedge clk);
        #2;
        tx_en = 1'b0;
        repeat (20) @(negedge clk);
        check("en_low_ready", tx_ready, 0);
        wait_idle();
        check("en_low_frames", frames_done - f0, 2);
        check("en_low_ready_end", tx_ready, 0);
        @(posedge clk);
        #2;
        tx_en = 1'b1;
        repeat (2) @(negedge clk);
        check("en_high_ready", tx_ready, 1);

`ifdef UART_TX_BREAK_EN
        mon_on = 0;
        @(posedge clk);
        #2;
        tx_break = 1'b1;
        @(negedge clk);
        check("break_line_low", uart_tx, 0);
        @(posedge clk);
        #2;
        tx_break = 1'b0;
        @(negedge clk);
        check("break_release_line", uart_tx, 1);
        @(posedge clk);
        #2;
        mon_on = 1;
`else
        tx_break = 1'b1;
`endif

        f0 = frames_done;
        for (int i = 0; i < 12; i++) begin
            send(9'($urandom), 7'($urandom));
            if ($urandom_range(0, 3) == 0) wait_idle();
        end
        wait_idle();
        check("random_frames", frames_done - f0, 12);
        tx_break = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
